// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - drains the result matrix from data memory onto a valid/ready stream
// Optional feature macro: UNLOAD_CHECKSUM_EN (appends a 16-bit wrap-around sum beat).
module result_unloader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int NCORES   = 4,
  parameter int HDR_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCORES-1:0] core_mask_i,
  input  logic [NCORES-1:0] end_process_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CALC, S_STREAM, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        hdr_cnt_q;
  logic [7:0]        dim_i_q, dim_j_q, dim_k_q;
  logic [16:0]       remaining_q, beats_left_q;
  logic              vld_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;
  logic              busy_q, done_q, err_q;
`ifdef UNLOAD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              cks_pend_q;
`endif

  logic              trigger, pop, issue, push, cks_push, over;
  logic [16:0]       base, count;
  logic [2:0]        occ_after_pop;
  logic [DATA_W-1:0] push_data;

  // The memory read has no side effects, so mem_addr is always the next stream
  // address; a read only "counts" in the cycle where issue is asserted.
  always_comb begin
    trigger       = (core_mask_i != '0) && (end_process_i == core_mask_i);
    pop           = (occ_q != 2'd0) && out_ready_i;
    base          = 17'(HDR_BASE + 3) + 17'(dim_i_q) * 17'(dim_j_q)
                  + 17'(dim_j_q) * 17'(dim_k_q);
    count         = 17'(dim_i_q) * 17'(dim_k_q);
    over          = ({1'b0, base} + {1'b0, count}) > 18'(2 ** ADDR_W);
    occ_after_pop = {1'b0, occ_q} - 3'(pop);
    issue         = (state_q == S_STREAM) && (remaining_q != 17'd0)
                  && ((occ_after_pop + 3'(vld_q)) < 3'd2);
`ifdef UNLOAD_CHECKSUM_EN
    cks_push      = (state_q == S_STREAM) && (remaining_q == 17'd0) && !vld_q
                  && cks_pend_q && (occ_after_pop < 3'd2);
    push_data     = cks_push ? sum_q : mem_rd_data_i;
`else
    cks_push      = 1'b0;
    push_data     = mem_rd_data_i;
`endif
    push          = vld_q || cks_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      hdr_cnt_q    <= 2'd0;
      dim_i_q      <= 8'd0;
      dim_j_q      <= 8'd0;
      dim_k_q      <= 8'd0;
      remaining_q  <= 17'd0;
      beats_left_q <= 17'd0;
      vld_q        <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
      sum_q        <= '0;
      cks_pend_q   <= 1'b0;
`endif
    end else begin
      vld_q <= issue;
      if (issue) begin
        rd_addr_q   <= rd_addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - 17'd1;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q     <= ~rd_ptr_q;
        beats_left_q <= beats_left_q - 17'd1;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
`ifdef UNLOAD_CHECKSUM_EN
      if (vld_q)    sum_q      <= sum_q + mem_rd_data_i;
      if (cks_push) cks_pend_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q   <= S_HDR;
            rd_addr_q <= ADDR_W'(HDR_BASE);
            hdr_cnt_q <= 2'd0;
            busy_q    <= 1'b1;
          end
        end
        S_HDR: begin
          hdr_cnt_q <= hdr_cnt_q + 2'd1;
          if (hdr_cnt_q < 2'd2) rd_addr_q <= rd_addr_q + ADDR_W'(1);
          case (hdr_cnt_q)
            2'd1:    dim_i_q <= mem_rd_data_i[7:0];
            2'd2:    dim_j_q <= mem_rd_data_i[7:0];
            2'd3: begin
              dim_k_q <= mem_rd_data_i[7:0];
              state_q <= S_CALC;
            end
            default: ;
          endcase
        end
        S_CALC: begin
          if (count == 17'd0) begin
`ifdef UNLOAD_CHECKSUM_EN
            state_q      <= S_STREAM;
            remaining_q  <= 17'd0;
            beats_left_q <= 17'd1;
            sum_q        <= '0;
            cks_pend_q   <= 1'b1;
`else
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
`endif
          end else if (over) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q     <= S_STREAM;
            rd_addr_q   <= base[ADDR_W-1:0];
            remaining_q <= count;
`ifdef UNLOAD_CHECKSUM_EN
            beats_left_q <= count + 17'd1;
            sum_q        <= '0;
            cks_pend_q   <= 1'b1;
`else
            beats_left_q <= count;
`endif
          end
        end
        S_STREAM: begin
          if (pop && (beats_left_q == 17'd1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (end_process_i == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr_o  = rd_addr_q;
  assign out_data_o  = fifo_q[rd_ptr_q];
  assign out_valid_o = (occ_q != 2'd0);
  assign out_last_o  = out_valid_o && (beats_left_q == 17'd1);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - scoreboard bench for result_unloader with random memory contents
module tb_result_unloader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  core_mask = 4'b0;
  logic [3:0]  end_process = 4'b0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data = 16'd0;
  logic [15:0] out_data;
  logic        out_valid, out_ready = 1'b1, out_last, busy, done, err;

  logic [15:0] mem [256];
  logic [16:0] exp_q [$];
  int checks = 0, errors = 0;
  int cyc = 0, ready_mode = 0, rpat = 0;
  int run_beats = 0, last_beat_cyc = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic prev_last = 1'b0;

  result_unloader dut (
    .clk(clk), .rst_n(rst_n), .core_mask_i(core_mask), .end_process_i(end_process),
    .mem_addr_o(mem_addr), .mem_rd_data_i(mem_rd_data), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ready generator: 0 = always high, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (rpat == 0 || rpat == 3 || rpat == 5);
        rpat = (rpat + 1) % 6;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake and watches stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e[15:0]);
          check("beat_last", out_last, e[16]);
        end
        if (ready_mode == 0 && run_beats > 0) check("beat_spacing", cyc, last_beat_cyc + 1);
        last_beat_cyc = cyc;
        run_beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Reference: matrix layout C follows A (i x j) and B (j x k) after the 3-word header
  task automatic model_push(input int di, input int dj, input int dk, output bit e_err);
    int base, cnt;
    logic [15:0] sum;
    base = 3 + di * dj + dj * dk;
    cnt = di * dk;
    sum = 16'd0;
    e_err = 1'b0;
    if (cnt == 0) begin
`ifdef UNLOAD_CHECKSUM_EN
      exp_q.push_back({1'b1, 16'd0});
`endif
    end else if (base + cnt > 256) begin
      e_err = 1'b1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        bit lst;
        lst = (i == cnt - 1);
`ifdef UNLOAD_CHECKSUM_EN
        lst = 1'b0;
`endif
        exp_q.push_back({lst, mem[base + i]});
        sum = sum + mem[base + i];
      end
`ifdef UNLOAD_CHECKSUM_EN
      exp_q.push_back({1'b1, sum});
`endif
    end
  endtask

  task automatic load_mem(input int di, input int dj, input int dk, input bit nominal);
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    mem[0] = 16'(di); mem[1] = 16'(dj); mem[2] = 16'(dk);
    if (nominal) begin
      mem[11] = 16'd19; mem[12] = 16'd22; mem[13] = 16'd43; mem[14] = 16'd50;
    end
  endtask

  task automatic wait_done_and_rearm(input bit e_err, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, e_err);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_valid_idle"}, out_valid, 0);
    end_process = 4'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rearm"}, done, 0);
    exp_q.delete();
  endtask

  task automatic do_run(input int di, input int dj, input int dk, input int rmode,
                        input bit nominal, input string tag);
    bit e_err;
    ready_mode = rmode;
    load_mem(di, dj, dk, nominal);
    model_push(di, dj, dk, e_err);
    run_beats = 0;
    @(negedge clk);
    core_mask = 4'b1111;
    end_process = 4'b1111;
    wait_done_and_rearm(e_err, tag);
  endtask

  initial begin
    bit e_err, got;
    for (int a = 0; a < 256; a++) mem[a] = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_addr", mem_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_run(2, 2, 2, 0, 1'b1, "nominal");
    do_run(2, 2, 2, 1, 1'b1, "backpressure");
    do_run(1, 1, 1, 0, 1'b0, "single");
    do_run(0, 3, 3, 0, 1'b0, "zero");
    do_run(16, 16, 16, 0, 1'b0, "overflow");
    for (int r = 0; r < 10; r++)
      do_run($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
             $urandom_range(0, 2), 1'b0, "random");

    // Partial mask: only an exact match of end_process to core_mask triggers
    ready_mode = 0;
    load_mem(2, 2, 2, 1'b1);
    core_mask = 4'b1000;
    end_process = 4'b0100;
    repeat (12) @(negedge clk);
    check("mask_nomatch_busy", busy, 0);
    check("mask_nomatch_done", done, 0);
    model_push(2, 2, 2, e_err);
    run_beats = 0;
    end_process = 4'b1000;
    wait_done_and_rearm(e_err, "mask_match");
    end_process = 4'b1100;
    repeat (12) @(negedge clk);
    check("mask_superset_busy", busy, 0);
    check("mask_superset_done", done, 0);
    end_process = 4'b0;
    @(negedge clk);

    // Reset in the middle of a nominal stream, then replay
    load_mem(2, 2, 2, 1'b1);
    model_push(2, 2, 2, e_err);
    run_beats = 0;
    core_mask = 4'b1111;
    end_process = 4'b1111;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (run_beats >= 2) begin got = 1'b1; break; end
    end
    check("midrst_two_beats", got, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_addr", mem_addr, 0);
    check("midrst_data", out_data, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    model_push(2, 2, 2, e_err);
    run_beats = 0;
    rst_n = 1'b1;
    wait_done_and_rearm(e_err, "replay");
    check("replay_beats", run_beats, exp_q.size() + 4
`ifdef UNLOAD_CHECKSUM_EN
          + 1
`endif
    );

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
